// File: rtl/shift_delay_line_var.sv
// shift_delay_line_var: run-time programmable delay line for {valid, data}.
// A circular buffer of MAX_DELAY words, read (De-1) slots behind the write
// pointer, gives De enabled cycles of latency. De = 1 bypasses the buffer.
// A priming counter hides valid_o until the buffer holds De fresh words after
// reset or after a delay change.
// Optional build macro: VDELAY_FLUSH_EN -- blank data_o to 0 while not primed.
module shift_delay_line_var #(
  parameter int WIDTH     = 40,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DW-1:0]    delay_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             primed_o
);

  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D    = DW'(MAX_DELAY);
  localparam logic [DW-1:0] ONE_D    = DW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_DELAY - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // Map the requested delay into the supported range 1..MAX_DELAY.
  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (d == '0)
      r = ONE_D;
    else if (d > MAX_D)
      r = MAX_D;
    return r;
  endfunction

  // Increment the priming count, holding once it reaches MAX_DELAY.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] c);
    logic [DW-1:0] r;
    r = c;
    if (c != MAX_D)
      r = c + ONE_D;
    return r;
  endfunction

  // Stored word is {valid, data}.
  logic [WIDTH:0]    mem [MAX_DELAY];
  logic [PW-1:0]     wr_ptr;
  logic [DW-1:0]     d_cur;
  logic [DW-1:0]     prime_cnt;

  logic [DW-1:0]     de;
  logic [PW-1:0]     delta;
  logic [PW-1:0]     rd_idx;
  logic [WIDTH:0]    rd_word;
  logic [DW-1:0]     prime_nxt;
  logic              primed_nxt;

  // Effective delay for this edge; the new delay takes effect immediately.
  always_comb begin
    de = clamp_delay(delay_i);
  end

  // Read index = (wr_ptr - (De-1)) mod MAX_DELAY, kept non-negative by
  // wrapping from PTR_LAST when the offset reaches past slot 0.
  always_comb begin
    delta   = PW'(de - ONE_D);
    rd_idx  = (wr_ptr >= delta) ? (wr_ptr - delta)
                                : (PTR_LAST - (delta - wr_ptr - PTR_ONE));
    rd_word = (de == ONE_D) ? {valid_i, data_i} : mem[rd_idx];
  end

  // Priming: restart on a delay change, otherwise count up to saturation.
  always_comb begin
    prime_nxt  = (de != d_cur) ? '0 : sat_inc(prime_cnt);
    primed_nxt = (prime_nxt >= de);
  end

  // Circular buffer storage, written at wr_ptr on every enabled edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_DELAY; i++)
        mem[i] <= '0;
    end else if (en) begin
      mem[wr_ptr] <= {valid_i, data_i};
    end
  end

  // Pointer, delay tracking, priming and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      d_cur     <= ONE_D;
      prime_cnt <= '0;
      primed_o  <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
    end else if (en) begin
      wr_ptr    <= (wr_ptr == PTR_LAST) ? '0 : (wr_ptr + PTR_ONE);
      d_cur     <= de;
      prime_cnt <= prime_nxt;
      primed_o  <= primed_nxt;
      valid_o   <= rd_word[WIDTH] & primed_nxt;
`ifdef VDELAY_FLUSH_EN
      data_o    <= primed_nxt ? rd_word[WIDTH-1:0] : '0;
`else
      data_o    <= rd_word[WIDTH-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_shift_delay_line_var.sv
// Directed bench for shift_delay_line_var (WIDTH=40, MAX_DELAY=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_shift_delay_line_var;

  localparam int WIDTH     = 40;
  localparam int MAX_DELAY = 16;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic             clk;
  logic             reset_n;
  logic             en;
  logic [DW-1:0]    delay_i;
  logic             valid_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             primed_o;

  int errors;
  int checks;

  shift_delay_line_var #(
    .WIDTH(WIDTH),
    .MAX_DELAY(MAX_DELAY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .delay_i(delay_i),
    .valid_i(valid_i),
    .data_i(data_i),
    .valid_o(valid_o),
    .data_o(data_o),
    .primed_o(primed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    en      = 1'b1;
    delay_i = DW'(1);
    valid_i = 1'b1;
    data_i  = 40'h55;
    #1;
    checks++;
    if (data_o !== '0 || valid_o !== 1'b0 || primed_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: data=%0h valid=%b primed=%b, want 0 0 0", data_o, valid_o, primed_o);
    end
    tick();
    tick();
    checks++;
    if (data_o !== '0 || valid_o !== 1'b0 || primed_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: data=%0h valid=%b primed=%b, want 0 0 0", data_o, valid_o, primed_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_d1();
    delay_i = DW'(1);
    valid_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      data_i = 40'(k);
      tick();
      checks++;
      if (data_o !== 40'(k) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
        errors++;
        $display("FAIL d1 k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1", k, data_o, valid_o, primed_o, k);
      end
    end
  endtask

  task automatic test_d5();
    logic exp_v;
    delay_i = DW'(5);
    for (int k = 0; k < 60; k++) begin
      data_i  = 40'(100 + k);
      valid_i = ((k % 7) != 3);
      tick();
      if (k < 5) begin
        checks++;
        if (valid_o !== 1'b0 || primed_o !== 1'b0) begin
          errors++;
          $display("FAIL d5_prime k=%0d: valid=%b primed=%b, want 0 0", k, valid_o, primed_o);
        end
`ifdef VDELAY_FLUSH_EN
        checks++;
        if (data_o !== '0) begin
          errors++;
          $display("FAIL d5_flush k=%0d: data=%0d, want 0", k, data_o);
        end
`endif
      end else begin
        exp_v = (((k - 4) % 7) != 3);
        checks++;
        if (data_o !== 40'(100 + k - 4) || valid_o !== exp_v || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL d5 k=%0d: data=%0d valid=%b primed=%b, want %0d %b 1",
                   k, data_o, valid_o, primed_o, 100 + k - 4, exp_v);
        end
      end
    end
    valid_i = 1'b1;
  endtask

  task automatic test_clamp();
    delay_i = DW'(0);
    valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_i = 40'(200 + k);
      tick();
      if (k == 0) begin
        checks++;
        if (valid_o !== 1'b0 || primed_o !== 1'b0) begin
          errors++;
          $display("FAIL d0_change: valid=%b primed=%b, want 0 0", valid_o, primed_o);
        end
      end else begin
        checks++;
        if (data_o !== 40'(200 + k) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL d0_as_1 k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                   k, data_o, valid_o, primed_o, 200 + k);
        end
      end
    end
    delay_i = DW'(17);
    for (int k = 0; k < 26; k++) begin
      data_i = 40'(300 + k);
      tick();
      if (k < 16) begin
        checks++;
        if (valid_o !== 1'b0 || primed_o !== 1'b0) begin
          errors++;
          $display("FAIL d17_prime k=%0d: valid=%b primed=%b, want 0 0", k, valid_o, primed_o);
        end
      end else begin
        checks++;
        if (data_o !== 40'(300 + k - 15) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL d17_as_16 k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                   k, data_o, valid_o, primed_o, 300 + k - 15);
        end
      end
    end
    // 17 and 16 clamp to the same delay, so this is not a change.
    delay_i = DW'(16);
    for (int k = 26; k < 30; k++) begin
      data_i = 40'(300 + k);
      tick();
      checks++;
      if (data_o !== 40'(300 + k - 15) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
        errors++;
        $display("FAIL d16_same k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                 k, data_o, valid_o, primed_o, 300 + k - 15);
      end
    end
  endtask

  task automatic test_change();
    delay_i = DW'(4);
    valid_i = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 10) delay_i = DW'(7);
      data_i = 40'(400 + k);
      tick();
      if (k < 4 || (k >= 10 && k < 17)) begin
        checks++;
        if (valid_o !== 1'b0 || primed_o !== 1'b0) begin
          errors++;
          $display("FAIL chg_prime k=%0d: valid=%b primed=%b, want 0 0", k, valid_o, primed_o);
        end
`ifdef VDELAY_FLUSH_EN
        checks++;
        if (data_o !== '0) begin
          errors++;
          $display("FAIL chg_flush k=%0d: data=%0d, want 0", k, data_o);
        end
`else
        if (k == 10) begin
          checks++;
          if (data_o !== 40'(404)) begin
            errors++;
            $display("FAIL chg_first_new_read: data=%0d, want 404", data_o);
          end
        end
`endif
      end else if (k < 10) begin
        checks++;
        if (data_o !== 40'(400 + k - 3) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL chg_d4 k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                   k, data_o, valid_o, primed_o, 400 + k - 3);
        end
      end else begin
        checks++;
        if (data_o !== 40'(400 + k - 6) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL chg_d7 k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                   k, data_o, valid_o, primed_o, 400 + k - 6);
        end
      end
    end
  endtask

  task automatic test_stall();
    delay_i = DW'(3);
    valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_i = 40'(500 + k);
      tick();
    end
    checks++;
    if (data_o !== 40'(507) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre: data=%0d valid=%b primed=%b, want 507 1 1", data_o, valid_o, primed_o);
    end
    en      = 1'b0;
    delay_i = DW'(9);
    data_i  = 40'(999);
    valid_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      checks++;
      if (data_o !== 40'(507) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold s=%0d: data=%0d valid=%b primed=%b, want 507 1 1",
                 s, data_o, valid_o, primed_o);
      end
    end
    en      = 1'b1;
    delay_i = DW'(3);
    valid_i = 1'b1;
    for (int k = 10; k < 16; k++) begin
      data_i = 40'(500 + k);
      tick();
      checks++;
      if (data_o !== 40'(500 + k - 2) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_resume k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                 k, data_o, valid_o, primed_o, 500 + k - 2);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_o !== '0 || valid_o !== 1'b0 || primed_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_now: data=%0d valid=%b primed=%b, want 0 0 0", data_o, valid_o, primed_o);
    end
    tick();
    #2;
    reset_n = 1'b1;
    delay_i = DW'(3);
    valid_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_i = 40'(600 + k);
      tick();
      if (k < 3) begin
        checks++;
        if (valid_o !== 1'b0 || primed_o !== 1'b0) begin
          errors++;
          $display("FAIL areset_prime k=%0d: valid=%b primed=%b, want 0 0", k, valid_o, primed_o);
        end
        if (k < 2) begin
          checks++;
          if (data_o !== '0) begin
            errors++;
            $display("FAIL areset_cleared k=%0d: data=%0d, want 0", k, data_o);
          end
        end
      end else begin
        checks++;
        if (data_o !== 40'(600 + k - 2) || valid_o !== 1'b1 || primed_o !== 1'b1) begin
          errors++;
          $display("FAIL areset_resume k=%0d: data=%0d valid=%b primed=%b, want %0d 1 1",
                   k, data_o, valid_o, primed_o, 600 + k - 2);
        end
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b1;
    en      = 1'b0;
    delay_i = '0;
    valid_i = 1'b0;
    data_i  = '0;
    test_reset();
    test_d1();
    test_d5();
    test_clamp();
    test_change();
    test_stall();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
